// File: rtl/imem_loader.sv
// Boot loader for instruction memory: unpacks a length-prefixed byte stream into
// big-endian 32-bit words, writes them sequentially, and holds the CPU until done.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  load_req,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] length;
  logic [1:0]  byte_idx;
  logic [23:0] pack;
  logic        released;
  logic        accept;
  logic        last_word;
  logic        restart;
  logic [15:0] len_full;
  logic [32:0] end_addr;

  always_comb begin
    in_ready  = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA);
    accept    = in_valid && in_ready;
    restart   = load_req && ((state == S_DONE) || (state == S_ERROR));
    len_full  = {length[15:8], in_data};
    // One past the last word address; compared wide so large lengths cannot alias.
    end_addr  = 33'(BASE_ADDR) + 33'(len_full);
    last_word = (byte_idx == 2'd3) && (words_loaded == (length - 16'd1));

    state_nxt = state;
    case (state)
      S_LEN_HI: if (accept) state_nxt = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (len_full == 16'd0)
            state_nxt = S_DONE;
          else if (end_addr > (33'd1 << ADDR_WIDTH))
            state_nxt = S_ERROR;
          else
            state_nxt = S_DATA;
        end
      end
      S_DATA:  if (accept && last_word) state_nxt = S_DONE;
      S_DONE:  if (load_req) state_nxt = S_LEN_HI;
      S_ERROR: if (load_req) state_nxt = S_LEN_HI;
      default: state_nxt = S_LEN_HI;
    endcase

    // The first DONE cycle keeps the CPU held so the final write settles first.
    cpu_hold = !((state == S_DONE) && released);
    done     = (state == S_DONE) && released;
    error    = (state == S_ERROR);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_LEN_HI;
      released <= 1'b0;
    end else begin
      state    <= state_nxt;
      released <= (state == S_DONE) && (state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      length       <= '0;
      byte_idx     <= '0;
      pack         <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= ADDR_WIDTH'(BASE_ADDR);
      imem_wdata   <= '0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      if (restart) begin
        length       <= '0;
        byte_idx     <= '0;
        words_loaded <= '0;
      end else if (accept) begin
        case (state)
          S_LEN_HI: length[15:8] <= in_data;
          S_LEN_LO: length[7:0]  <= in_data;
          S_DATA: begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              imem_we      <= 1'b1;
              imem_wdata   <= {pack, in_data};
              imem_addr    <= ADDR_WIDTH'(32'(BASE_ADDR) + 32'(words_loaded));
              words_loaded <= words_loaded + 16'd1;
            end else begin
              pack <= {pack[15:0], in_data};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
